hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller that sequences the IF/ID pipeline register and the PC.
- Drives the IF/ID write-enable and flush, the PC write-enable, the ID/EX bubble select and a global hold for the downstream pipeline registers.
- Detects load-use hazards, runs multi-cycle stalls for branches resolved in ID, flushes on taken branches and jumps, and freezes the pipeline while data memory is busy.
- Sits in the ID stage beside the decoder.

Parameters:
BR_LU_STALLS, 2, total stall cycles when the ID instruction is a branch with a load-use hazard (range 1..7)
CNT_W, 32, width of the performance counters (optional feature only)

Ports:
clk_i  input  1  clock; all state updates on the rising edge
rst_i  input  1  asynchronous reset, active-low
mem_busy_i  input  1  data memory not ready; freeze the whole pipeline
idex_memread_i  input  1  instruction in EX is a load
idex_rt_i  input  5  destination register of the instruction in EX
ifid_rs_i  input  5  rs field of the instruction in ID
ifid_rt_i  input  5  rt field of the instruction in ID
is_branch_i  input  1  instruction in ID is a conditional branch
branch_taken_i  input  1  branch in ID resolved taken
jump_i  input  1  instruction in ID is a jump
pc_write_o  output  1  PC update enable
ifid_write_o  output  1  IF/ID register write enable
if_flush_o  output  1  IF/ID register flush
idex_bubble_o  output  1  select zero control word into ID/EX
pipe_hold_o  output  1  hold ID/EX, EX/MEM and MEM/WB registers
stall_cnt_o  output  CNT_W  stall-cycle count (optional feature)
flush_cnt_o  output  CNT_W  flush count (optional feature)

Behaviour:
- Hazard condition: haz = idex_memread_i & (idex_rt_i != 0) & ((idex_rt_i == ifid_rs_i) | (idex_rt_i == ifid_rt_i)).
- State: FSM with states RUN and STALL, plus a 3-bit down-counter cnt.
- Reset (rst_i low, async): state = RUN, cnt = 0.
- Outputs while in reset: pc_write_o=0, ifid_write_o=0, if_flush_o=0, idex_bubble_o=1, pipe_hold_o=0.
- Outputs are combinational from (state, cnt, inputs) and valid in the same cycle. Evaluate in the priority order below; the first matching rule applies.
- Priority 1, freeze (mem_busy_i=1), any state:
  - pc_write_o=0, ifid_write_o=0, if_flush_o=0, idex_bubble_o=0, pipe_hold_o=1.
  - state and cnt unchanged.
  - A branch or jump in ID stays stable and is acted on in the first non-busy cycle.
- Priority 2, STALL:
  - pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, if_flush_o=0.
  - cnt decrements. When cnt==1 this cycle, the next state is RUN.
  - branch_taken_i and jump_i are ignored (operands not yet valid).
- Priority 3, RUN with haz=1: same stall outputs as STALL.
  - If is_branch_i=1 and BR_LU_STALLS>1: load cnt=BR_LU_STALLS-1 and go to STALL.
  - Otherwise remain in RUN (the hazard clears once the bubble advances).
  - Branch and jump are ignored in this cycle.
- Priority 4, RUN with haz=0 and (branch_taken_i | jump_i): if_flush_o=1, pc_write_o=1, ifid_write_o=1, idex_bubble_o=0.
- Priority 5, RUN idle: pc_write_o=1, ifid_write_o=1, if_flush_o=0, idex_bubble_o=0, pipe_hold_o=0.
- Total stall length: a branch with a load-use hazard stalls exactly BR_LU_STALLS non-busy cycles. A non-branch with a hazard stalls exactly 1 cycle.
- Busy cycles inside a stall extend it without consuming cnt.
- if_flush_o is never asserted together with ifid_write_o=0.
- Register $0 never causes a hazard.
- If rst_i is asserted mid-stall, state returns to RUN and cnt to 0 immediately; no stall resumes after release.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined:
  - stall_cnt_o increments on every cycle with idex_bubble_o=1 and mem_busy_i=0.
  - flush_cnt_o increments on every cycle with if_flush_o=1.
  - Both counters saturate at all-ones and reset to 0.
- Undefined: the counter logic is removed. Both ports remain in the port list and are tied to 0.

Test Plan:
- Reset: rst_i=0 with random inputs -> pc_write_o=0, ifid_write_o=0, idex_bubble_o=1. After release with no hazard -> pc_write_o=1, ifid_write_o=1.
- Load-use: idex_memread_i=1, idex_rt_i=5, ifid_rs_i=5, is_branch_i=0 -> exactly 1 stall cycle (pc_write_o=0, idex_bubble_o=1), then normal flow.
- Branch plus load: same hazard with is_branch_i=1, BR_LU_STALLS=2, branch_taken_i=1 throughout -> 2 stall cycles with if_flush_o=0, then 1 cycle of if_flush_o=1.
- Freeze: mem_busy_i=1 for 3 cycles in the middle of a branch stall -> pipe_hold_o=1 on those 3 cycles. The stall still totals 2 non-busy cycles. A jump_i held during busy flushes only after busy drops.
- Zero register: idex_rt_i=0 with matching ifid_rs_i=0 and idex_memread_i=1 -> no stall.
- Perf (with HAZARD_PERF_EN): 1 load-use stall plus 1 jump -> stall_cnt_o=1, flush_cnt_o=1. Without the macro, both read 0.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: ID-stage hazard inputs and the pipeline control outputs.
// The master side (decoder/pipeline) drives the *_i signals; the hazard
// controller (slave) drives the *_o signals.
interface hazard_ctrl_if;
    logic       mem_busy_i;
    logic       idex_memread_i;
    logic [4:0] idex_rt_i;
    logic [4:0] ifid_rs_i;
    logic [4:0] ifid_rt_i;
    logic       is_branch_i;
    logic       branch_taken_i;
    logic       jump_i;
    logic       pc_write_o;
    logic       ifid_write_o;
    logic       if_flush_o;
    logic       idex_bubble_o;
    logic       pipe_hold_o;

    modport master (
        output mem_busy_i, idex_memread_i, idex_rt_i, ifid_rs_i, ifid_rt_i,
               is_branch_i, branch_taken_i, jump_i,
        input  pc_write_o, ifid_write_o, if_flush_o, idex_bubble_o, pipe_hold_o
    );

    modport slave (
        input  mem_busy_i, idex_memread_i, idex_rt_i, ifid_rs_i, ifid_rt_i,
               is_branch_i, branch_taken_i, jump_i,
        output pc_write_o, ifid_write_o, if_flush_o, idex_bubble_o, pipe_hold_o
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the IF/ID register and the PC.
// Handles load-use stalls, multi-cycle stalls for branches resolved in ID that
// depend on a load, flushes on taken branches/jumps, and a full freeze while
// data memory is busy. Outputs are combinational from state and inputs.
// Optional performance counters are enabled with the macro HAZARD_PERF_EN;
// without it stall_cnt_o and flush_cnt_o are tied to zero.
module hazard_ctrl #(
    parameter int BR_LU_STALLS = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    hazard_ctrl_if.slave     bus,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    typedef enum logic {RUN, STALL} state_t;

    state_t     state, state_next;
    logic [2:0] cnt, cnt_next;
    logic       haz;
    logic       pc_write, ifid_write, if_flush, idex_bubble, pipe_hold;

    // Load-use hazard: the load in EX writes a register the ID instruction reads
    assign haz = bus.idex_memread_i && (bus.idex_rt_i != 5'd0) &&
                 ((bus.idex_rt_i == bus.ifid_rs_i) || (bus.idex_rt_i == bus.ifid_rt_i));

    // Priority-ordered output decode and next-state selection
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        if_flush    = 1'b0;
        idex_bubble = 1'b0;
        pipe_hold   = 1'b0;
        if (!rst_i) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end else if (bus.mem_busy_i) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            pipe_hold  = 1'b1;
        end else if (state == STALL) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            cnt_next    = cnt - 3'd1;
            if (cnt == 3'd1) begin
                state_next = RUN;
            end
        end else if (haz) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            if (bus.is_branch_i && (BR_LU_STALLS > 1)) begin
                cnt_next   = 3'(BR_LU_STALLS - 1);
                state_next = STALL;
            end
        end else if (bus.branch_taken_i || bus.jump_i) begin
            if_flush = 1'b1;
        end
    end

    // State and stall counter register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= RUN;
            cnt   <= 3'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    assign bus.pc_write_o    = pc_write;
    assign bus.ifid_write_o  = ifid_write;
    assign bus.if_flush_o    = if_flush;
    assign bus.idex_bubble_o = idex_bubble;
    assign bus.pipe_hold_o   = pipe_hold;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    // Saturating counters of bubble cycles and flush cycles
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (idex_bubble && !bus.mem_busy_i && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (if_flush && (flush_cnt != {CNT_W{1'b1}})) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

    assign stall_cnt_o = stall_cnt;
    assign flush_cnt_o = flush_cnt;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: directed sequences from the test plan followed by
// randomized traffic, checked by a scoreboard against a behavioural model.
// Counter expectations follow the HAZARD_PERF_EN build setting.
module tb_hazard_ctrl;

    localparam int BR_LU = 2;
    localparam int CW    = 32;

    typedef struct {
        logic          pc;
        logic          ifid;
        logic          flush;
        logic          bubble;
        logic          hold;
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;
    } exp_t;

    logic          clk_i;
    logic          rst_i;
    logic [CW-1:0] stall_cnt_o;
    logic [CW-1:0] flush_cnt_o;

    hazard_ctrl_if bus ();

    hazard_ctrl #(.BR_LU_STALLS(BR_LU), .CNT_W(CW)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .bus         (bus),
        .stall_cnt_o (stall_cnt_o),
        .flush_cnt_o (flush_cnt_o)
    );

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state: forced stall cycles still owed, and event counts
    int          owed = 0;
    longint      m_stalls = 0;
    longint      m_flushes = 0;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Compare one output field and record the result
    task automatic check_output(input string name, input logic [CW-1:0] act, input logic [CW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    // Drive one cycle of inputs, predict the response and queue it
    task automatic apply_stimulus(input logic rst, input logic busy, input logic memread,
                                  input logic [4:0] ex_rt, input logic [4:0] rs, input logic [4:0] rt,
                                  input logic br, input logic taken, input logic jmp);
        exp_t e;
        logic hz;
        @(posedge clk_i);
        #1;
        rst_i              = rst;
        bus.mem_busy_i     = busy;
        bus.idex_memread_i = memread;
        bus.idex_rt_i      = ex_rt;
        bus.ifid_rs_i      = rs;
        bus.ifid_rt_i      = rt;
        bus.is_branch_i    = br;
        bus.branch_taken_i = taken;
        bus.jump_i         = jmp;

        hz = memread && (ex_rt != 0) && (ex_rt == rs || ex_rt == rt);
        if (!rst) begin
            owed = 0;
            m_stalls = 0;
            m_flushes = 0;
        end
`ifdef HAZARD_PERF_EN
        e.sc = CW'(m_stalls);
        e.fc = CW'(m_flushes);
`else
        e.sc = '0;
        e.fc = '0;
`endif
        if (!rst) begin
            e.pc = 0; e.ifid = 0; e.flush = 0; e.bubble = 1; e.hold = 0;
        end else if (busy) begin
            e.pc = 0; e.ifid = 0; e.flush = 0; e.bubble = 0; e.hold = 1;
        end else if (owed > 0) begin
            e.pc = 0; e.ifid = 0; e.flush = 0; e.bubble = 1; e.hold = 0;
            owed--;
        end else if (hz) begin
            e.pc = 0; e.ifid = 0; e.flush = 0; e.bubble = 1; e.hold = 0;
            owed = br ? BR_LU - 1 : 0;
        end else if (taken || jmp) begin
            e.pc = 1; e.ifid = 1; e.flush = 1; e.bubble = 0; e.hold = 0;
        end else begin
            e.pc = 1; e.ifid = 1; e.flush = 0; e.bubble = 0; e.hold = 0;
        end
        if (rst) begin
            if (e.bubble && !busy) m_stalls++;
            if (e.flush) m_flushes++;
        end
        exp_q.push_back(e);
    endtask

    // Monitor: every falling edge, pop the pending prediction and compare
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_output("pc_write",    {31'd0, bus.pc_write_o},    {31'd0, e.pc});
                check_output("ifid_write",  {31'd0, bus.ifid_write_o},  {31'd0, e.ifid});
                check_output("if_flush",    {31'd0, bus.if_flush_o},    {31'd0, e.flush});
                check_output("idex_bubble", {31'd0, bus.idex_bubble_o}, {31'd0, e.bubble});
                check_output("pipe_hold",   {31'd0, bus.pipe_hold_o},   {31'd0, e.hold});
                check_output("stall_cnt",   stall_cnt_o, e.sc);
                check_output("flush_cnt",   flush_cnt_o, e.fc);
            end
        end
    end

    // Directed sequences, then random traffic, then drain and summarize
    initial begin
        rst_i = 1'b0;
        bus.mem_busy_i = 0; bus.idex_memread_i = 0; bus.idex_rt_i = 0;
        bus.ifid_rs_i = 0; bus.ifid_rt_i = 0; bus.is_branch_i = 0;
        bus.branch_taken_i = 0; bus.jump_i = 0;

        // Reset with random inputs
        for (int i = 0; i < 3; i++)
            apply_stimulus(0, 1'($urandom), 1'($urandom), 5'($urandom), 5'($urandom),
                           5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Load-use, non-branch: one stall then normal flow
        apply_stimulus(1, 0, 1, 5, 5, 0, 0, 0, 0);
        apply_stimulus(1, 0, 0, 5, 5, 0, 0, 0, 0);
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Branch plus load, taken throughout
        apply_stimulus(1, 0, 1, 5, 5, 0, 1, 1, 0);
        apply_stimulus(1, 0, 1, 5, 5, 0, 1, 1, 0);
        apply_stimulus(1, 0, 0, 5, 5, 0, 1, 1, 0);
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Freeze inside a branch stall, then a jump held across busy
        apply_stimulus(1, 0, 1, 7, 3, 7, 1, 1, 0);
        for (int i = 0; i < 3; i++) apply_stimulus(1, 1, 1, 7, 3, 7, 1, 1, 0);
        apply_stimulus(1, 0, 1, 7, 3, 7, 1, 1, 0);
        apply_stimulus(1, 0, 0, 7, 3, 7, 1, 1, 0);
        for (int i = 0; i < 2; i++) apply_stimulus(1, 1, 0, 0, 0, 0, 0, 0, 1);
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 1);

        // Register zero never stalls
        apply_stimulus(1, 0, 1, 0, 0, 0, 0, 0, 0);

        // Reset mid-stall, then counters from zero: one load-use stall and one jump
        apply_stimulus(1, 0, 1, 9, 9, 0, 1, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        apply_stimulus(1, 0, 1, 4, 0, 4, 0, 0, 0);
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 1);
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Randomized traffic with small register numbers to provoke hazards
        for (int i = 0; i < 2000; i++)
            apply_stimulus(($urandom_range(0, 99) >= 2), ($urandom_range(0, 99) < 20),
                           1'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                           5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                           ($urandom_range(0, 99) < 25));

        repeat (3) @(negedge clk_i);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
